rw_stage_pipelined: RTL and testbench

//   Parametrised register-writeback (RW) stage with its own MA->RW pipeline register.

---
 rtl/rw_stage_pipelined_pkg.sv | 16 +
 rtl/rw_stage_pipelined_if.sv | 49 ++++
 rtl/rw_stage_pipelined_pipe_reg.sv | 28 ++
 rtl/rw_stage_pipelined.sv | 106 ++++++++++
 tb/tb_rw_stage_pipelined.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rw_stage_pipelined_pkg.sv
// rtl/rw_stage_pipelined_pkg.sv - rw_pkg: result-select enum and default stage constants
package rw_pkg;

    typedef enum logic [1:0] {
        SEL_ALU,
        SEL_LD,
        SEL_PC
    } rw_sel_e;

    localparam int RW_IS_LD_B   = 1;
    localparam int RW_IS_WB_B   = 6;
    localparam int RW_IS_CALL_B = 8;
    localparam int RW_RA_IDX    = 15;
    localparam int RW_PC_STEP   = 4;

endpackage

// File: rtl/rw_stage_pipelined_if.sv
// rtl/rw_stage_pipelined_if.sv - MA->RW input bus and register-file write port; RW_BYPASS_EN adds forwarding compare
interface rw_stage_pipelined_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CTRL_W = 22,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_ld_result;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_ir;
    logic [CTRL_W-1:0] in_ctrl;
    logic              stall;
    logic              flush;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              rw_valid;
    logic [CNT_W-1:0]  retired_cnt;
`ifdef RW_BYPASS_EN
    logic [REG_AW-1:0] fwd_ra_addr;
    logic [REG_AW-1:0] fwd_rb_addr;
    logic              fwd_ra_hit;
    logic              fwd_rb_hit;

    modport master (
        output in_valid, in_pc, in_ld_result, in_alu_result, in_ir, in_ctrl,
        output stall, flush, fwd_ra_addr, fwd_rb_addr,
        input  wb_en, wb_rd, wb_data, rw_valid, retired_cnt, fwd_ra_hit, fwd_rb_hit
    );
    modport slave (
        input  in_valid, in_pc, in_ld_result, in_alu_result, in_ir, in_ctrl,
        input  stall, flush, fwd_ra_addr, fwd_rb_addr,
        output wb_en, wb_rd, wb_data, rw_valid, retired_cnt, fwd_ra_hit, fwd_rb_hit
    );
`else
    modport master (
        output in_valid, in_pc, in_ld_result, in_alu_result, in_ir, in_ctrl,
        output stall, flush,
        input  wb_en, wb_rd, wb_data, rw_valid, retired_cnt
    );
    modport slave (
        input  in_valid, in_pc, in_ld_result, in_alu_result, in_ir, in_ctrl,
        input  stall, flush,
        output wb_en, wb_rd, wb_data, rw_valid, retired_cnt
    );
`endif
endinterface

// File: rtl/rw_stage_pipelined_pipe_reg.sv
// rtl/rw_stage_pipelined_pipe_reg.sv - rw_pipe_reg: valid + payload register, reset > flush > stall > load
module rw_pipe_reg #(
    parameter int PAY_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [PAY_W-1:0] in_payload,
    output logic             valid,
    output logic [PAY_W-1:0] payload
);

    // Flush only clears valid; payload is don't-care once invalid, so it is left alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            payload <= '0;
        end else if (flush) begin
            valid   <= 1'b0;
        end else if (!stall) begin
            valid   <= in_valid;
            payload <= in_payload;
        end
    end

endmodule

// File: rtl/rw_stage_pipelined.sv
// rtl/rw_stage_pipelined.sv - register-writeback stage with MA->RW register; RW_BYPASS_EN enables fwd_* compare
module rw_stage_pipelined
    import rw_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 4,
    parameter int CTRL_W    = 22,
    parameter int IS_LD_B   = RW_IS_LD_B,
    parameter int IS_WB_B   = RW_IS_WB_B,
    parameter int IS_CALL_B = RW_IS_CALL_B,
    parameter int RD_LO     = 22,
    parameter int RA_IDX    = RW_RA_IDX,
    parameter int PC_STEP   = RW_PC_STEP,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    rw_stage_pipelined_if.slave  bus
);

    localparam int PAY_W = 4 * DATA_W + CTRL_W;

    logic              r_valid;
    logic [PAY_W-1:0]  pay_d;
    logic [PAY_W-1:0]  pay_q;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ld;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_ir;
    logic [CTRL_W-1:0] r_ctrl;
    logic              is_ld;
    logic              is_wb;
    logic              is_call;
    rw_sel_e           sel;
    logic [DATA_W-1:0] wb_data_c;
    logic [REG_AW-1:0] wb_rd_c;
    logic [CNT_W-1:0]  cnt_q;
    logic              unused_fields;

    assign pay_d = {bus.in_pc, bus.in_ld_result, bus.in_alu_result, bus.in_ir, bus.in_ctrl};

    rw_pipe_reg #(.PAY_W(PAY_W)) u_pipe_reg (
        .clk        (clk),
        .reset      (reset),
        .stall      (bus.stall),
        .flush      (bus.flush),
        .in_valid   (bus.in_valid),
        .in_payload (pay_d),
        .valid      (r_valid),
        .payload    (pay_q)
    );

    assign {r_pc, r_ld, r_alu, r_ir, r_ctrl} = pay_q;

    // Only a few IR/ctrl bits are decoded; the rest are carried but not consumed here.
    assign unused_fields = ^{r_ir, r_ctrl};

    assign is_ld   = r_ctrl[IS_LD_B];
    assign is_wb   = r_ctrl[IS_WB_B];
    assign is_call = r_ctrl[IS_CALL_B];

    // Result select: a call always links, even if the load bit is also set.
    always_comb begin
        sel = SEL_ALU;
        if (is_call) begin
            sel = SEL_PC;
        end else if (is_ld) begin
            sel = SEL_LD;
        end
    end

    // Writeback data mux; the link address wraps modulo 2^DATA_W.
    always_comb begin
        wb_data_c = r_alu;
        case (sel)
            SEL_PC:  wb_data_c = r_pc + DATA_W'(PC_STEP);
            SEL_LD:  wb_data_c = r_ld;
            default: wb_data_c = r_alu;
        endcase
    end

    assign wb_rd_c = is_call ? REG_AW'(RA_IDX) : r_ir[RD_LO+REG_AW-1:RD_LO];

    // Count an instruction on the edge it leaves the stage; flushed or held ones don't count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (r_valid && !bus.stall && !bus.flush) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Write is masked during stall so a held instruction writes once, on its last cycle.
    assign bus.wb_en       = r_valid & is_wb & ~bus.stall;
    assign bus.wb_rd       = wb_rd_c;
    assign bus.wb_data     = wb_data_c;
    assign bus.rw_valid    = r_valid;
    assign bus.retired_cnt = cnt_q;

`ifdef RW_BYPASS_EN
    // Hits ignore stall: the pending value on wb_data is already final.
    assign bus.fwd_ra_hit = r_valid & is_wb & (bus.fwd_ra_addr == wb_rd_c);
    assign bus.fwd_rb_hit = r_valid & is_wb & (bus.fwd_rb_addr == wb_rd_c);
`endif

endmodule

// File: tb/tb_rw_stage_pipelined.sv
// tb/tb_rw_stage_pipelined.sv - scoreboard bench for rw_stage_pipelined; RW_BYPASS_EN adds forwarding checks
module tb_rw_stage_pipelined;

    localparam logic [21:0] CT_LD   = 22'h000002;
    localparam logic [21:0] CT_WB   = 22'h000040;
    localparam logic [21:0] CT_CALL = 22'h000100;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;
    logic [35:0] exp_q[$];

    rw_stage_pipelined_if bus ();

    rw_stage_pipelined dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ir_rd(input int rd);
        return 32'(rd) << 22;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ld,
                         input logic [31:0] alu, input logic [31:0] ir, input logic [21:0] ctrl);
        bus.in_valid      = v;
        bus.in_pc         = pc;
        bus.in_ld_result  = ld;
        bus.in_alu_result = alu;
        bus.in_ir         = ir;
        bus.in_ctrl       = ctrl;
    endtask

    // Monitor: every observed register-file write must match the next expected write.
    always @(negedge clk) begin
        if (bus.wb_en === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write",
                         bus.wb_rd, bus.wb_data);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({bus.wb_rd, bus.wb_data} !== e) begin
                    fails++;
                    $display("FAIL write: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                             bus.wb_rd, bus.wb_data, e[35:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
`ifdef RW_BYPASS_EN
        bus.fwd_ra_addr = '0;
        bus.fwd_rb_addr = '0;
`endif
        drive(1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset_wb_en", 64'(bus.wb_en), 0);
        chk("reset_rw_valid", 64'(bus.rw_valid), 0);
        chk("reset_cnt", 64'(bus.retired_cnt), 0);
        chk("reset_wb_rd", 64'(bus.wb_rd), 0);
        chk("reset_wb_data", 64'(bus.wb_data), 0);
        reset = 1'b0;

        // ALU write
        drive(1'b1, 32'h40, 32'h0, 32'hDEADBEEF, ir_rd(5), CT_WB);
        exp_q.push_back({4'd5, 32'hDEADBEEF});
        tick();
        drive(1'b0, 0, 0, 0, 0, 0);
        chk("alu_valid", 64'(bus.rw_valid), 1);
        chk("alu_cnt_before", 64'(bus.retired_cnt), 0);
        tick();
        exp_cnt = 1;
        chk("alu_cnt", 64'(bus.retired_cnt), 64'(exp_cnt));

        // Calls: normal, wrapping link, call+load together
        drive(1'b1, 32'h100, 32'h0, 32'h1, ir_rd(1), CT_CALL | CT_WB);
        exp_q.push_back({4'd15, 32'h104});
        tick();
        drive(1'b1, 32'hFFFFFFFC, 32'h0, 32'h2, ir_rd(1), CT_CALL | CT_WB);
        exp_q.push_back({4'd15, 32'h0});
        tick();
        drive(1'b1, 32'h200, 32'h1234, 32'h3, ir_rd(3), CT_CALL | CT_LD | CT_WB);
        exp_q.push_back({4'd15, 32'h204});
        tick();
        drive(1'b0, 0, 0, 0, 0, 0);
        tick();
        exp_cnt = 4;
        chk("call_cnt", 64'(bus.retired_cnt), 64'(exp_cnt));

        // Non-writing instruction still retires
        drive(1'b1, 32'h0, 32'h0, 32'h77, ir_rd(3), 22'h0);
        tick();
        drive(1'b0, 0, 0, 0, 0, 0);
        chk("nowb_valid", 64'(bus.rw_valid), 1);
        chk("nowb_wb_en", 64'(bus.wb_en), 0);
        tick();
        exp_cnt = 5;
        chk("nowb_cnt", 64'(bus.retired_cnt), 64'(exp_cnt));

        // Load stalled three cycles: single write on release
        drive(1'b1, 32'h0, 32'h55, 32'h99, ir_rd(2), CT_LD | CT_WB);
        exp_q.push_back({4'd2, 32'h55});
        tick();
        drive(1'b1, 32'h0, 32'h0, 32'hAAAA, ir_rd(4), CT_WB);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_wb_en", 64'(bus.wb_en), 0);
            chk("stall_hold_data", 64'(bus.wb_data), 64'h55);
            tick();
        end
        chk("stall_cnt", 64'(bus.retired_cnt), 64'(exp_cnt));
        bus.stall = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0);
        #1;
        chk("release_wb_en", 64'(bus.wb_en), 1);
        tick();
        exp_cnt = 6;
        chk("release_cnt", 64'(bus.retired_cnt), 64'(exp_cnt));
        chk("release_valid", 64'(bus.rw_valid), 0);

        // Flush while stalled drops the held instruction
        drive(1'b1, 32'h0, 32'h0, 32'h1111, ir_rd(9), CT_WB);
        tick();
        drive(1'b0, 0, 0, 0, 0, 0);
        bus.stall = 1'b1;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        chk("flush_stall_valid", 64'(bus.rw_valid), 0);
        chk("flush_stall_cnt", 64'(bus.retired_cnt), 64'(exp_cnt));
        tick();
        chk("flush_stall_cnt2", 64'(bus.retired_cnt), 64'(exp_cnt));

        // Flush on the same edge as an incoming instruction
        drive(1'b1, 32'h0, 32'h0, 32'h2222, ir_rd(10), CT_WB);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0);
        chk("flush_load_valid", 64'(bus.rw_valid), 0);
        tick();
        chk("flush_load_cnt", 64'(bus.retired_cnt), 64'(exp_cnt));

`ifdef RW_BYPASS_EN
        bus.fwd_ra_addr = 4'd7;
        bus.fwd_rb_addr = 4'd3;
        drive(1'b1, 32'h0, 32'h0, 32'h7777, ir_rd(7), CT_WB);
        exp_q.push_back({4'd7, 32'h7777});
        tick();
        drive(1'b0, 0, 0, 0, 0, 0);
        chk("fwd_ra_hit", 64'(bus.fwd_ra_hit), 1);
        chk("fwd_rb_hit", 64'(bus.fwd_rb_hit), 0);
        tick();
        exp_cnt++;
        drive(1'b1, 32'h0, 32'h0, 32'h7777, ir_rd(7), 22'h0);
        tick();
        drive(1'b0, 0, 0, 0, 0, 0);
        chk("fwd_nowb_ra_hit", 64'(bus.fwd_ra_hit), 0);
        chk("fwd_nowb_rb_hit", 64'(bus.fwd_rb_hit), 0);
        tick();
        exp_cnt++;
        chk("fwd_cnt", 64'(bus.retired_cnt), 64'(exp_cnt));
`endif

        // Reset with a valid ALU write in flight
        drive(1'b1, 32'h0, 32'h0, 32'hCAFE, ir_rd(6), CT_WB);
        exp_q.push_back({4'd6, 32'hCAFE});
        tick();
        drive(1'b0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_wb_en", 64'(bus.wb_en), 0);
        chk("midreset_valid", 64'(bus.rw_valid), 0);
        chk("midreset_cnt", 64'(bus.retired_cnt), 0);

        tick();
        tick();
        chk("pending_writes", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
